// File: rtl/arb8_pkg.sv
// Shared types and sizes for the 8-way arbiter.
// Width constants and the controller state encoding.
package arb8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/arb8_if.sv
// Request/grant bundle between requesters and arb8_ctrl.
// master drives req/done, slave (the arbiter) drives the grant.
interface arb8_if;
    import arb8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic             tout;

    modport master (
        output req, done,
        input  gnt_vld, gnt_idx, gnt_oh, tout
    );

    modport slave (
        input  req, done,
        output gnt_vld, gnt_idx, gnt_oh, tout
    );

endinterface

// File: rtl/arb8_prio_enc.sv
// 8:3 priority encoder, lowest index wins.
// any is high when at least one input bit is set.
module arb8_prio_enc
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/arb8_ctrl.sv
// 8-way grant/hold arbiter with hold timeout.
// Define ARB8_ROUND_ROBIN_EN for rotating priority; default is fixed.
module arb8_ctrl
    import arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic   clk,
    input  logic   rst,
    arb8_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [HOLD_W-1:0] hold_q, hold_nx;
    logic             tout_q, tout_nx;

    logic [N_REQ-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W-1:0] win;
    logic             any;

    arb8_prio_enc u_enc (
        .req (enc_in),
        .idx (enc_idx),
        .any (any)
    );

`ifdef ARB8_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    // Rotate so the pointer position lands on encoder bit 0.
    always_comb begin
        enc_in = '0;
        for (int j = 0; j < N_REQ; j++) begin
            enc_in[j] = bus.req[IDX_W'(j) + ptr_q];
        end
    end

    assign win = enc_idx + ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else if (state == IDLE && any)
            ptr_q <= win + IDX_W'(1);
    end
`else
    assign enc_in = bus.req;
    assign win    = enc_idx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            hold_q <= '0;
            tout_q <= 1'b0;
        end else begin
            state  <= state_nx;
            idx_q  <= idx_nx;
            hold_q <= hold_nx;
            tout_q <= tout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        hold_nx  = hold_q;
        tout_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = BUSY;
                    idx_nx   = win;
                    hold_nx  = '0;
                end
            end
            BUSY: begin
                hold_nx = hold_q + HOLD_W'(1);
                // done wins over a same-cycle timeout
                if (bus.done) begin
                    state_nx = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_nx = IDLE;
                    tout_nx  = 1'b1;
                end
            end
        endcase
    end

    assign bus.gnt_vld = (state == BUSY);
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_oh  = bus.gnt_vld ? (N_REQ'(1) << idx_q) : '0;
    assign bus.tout    = tout_q;

endmodule

// File: tb/tb_arb8_ctrl.sv
// Scoreboard bench for arb8_ctrl (MAX_HOLD=4).
// Expected owners are queued at request time and popped on grant.
module tb_arb8_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [2:0] model_ptr = 3'd0;
    logic [2:0] sb[$];
    logic [2:0] exp_idx;
    logic [2:0] last_idx;

    arb8_if bus ();

    arb8_ctrl #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_win(input logic [7:0] r,
                                             input logic [2:0] p);
        logic [2:0] j;
        for (int k = 0; k < 8; k++) begin
            j = p + 3'(k);
            if (r[j]) return j;
        end
        return 3'd0;
    endfunction

    // Queue the expected winner and advance the model pointer.
    task automatic push_exp(input logic [7:0] r);
        logic [2:0] w;
        w = model_win(r, model_ptr);
        sb.push_back(w);
`ifdef ARB8_ROUND_ROBIN_EN
        model_ptr = w + 3'd1;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_empty: scoreboard had no entry");
            exp_idx = 3'd0;
        end else begin
            exp_idx = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst      = 1'b1;
        #12;
        checks++; if (bus.gnt_vld !== 1'b0) begin errors++;
            $display("FAIL rst_vld: got %b want 0", bus.gnt_vld); end
        checks++; if (bus.gnt_idx !== 3'd0) begin errors++;
            $display("FAIL rst_idx: got %0d want 0", bus.gnt_idx); end
        checks++; if (bus.gnt_oh !== 8'h00) begin errors++;
            $display("FAIL rst_oh: got %h want 00", bus.gnt_oh); end
        checks++; if (bus.tout !== 1'b0) begin errors++;
            $display("FAIL rst_tout: got %b want 0", bus.tout); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 3'd0;
        tick();
    endtask

    task automatic test_fixed_grant();
        bus.req = 8'b1010_0100;
        push_exp(bus.req);
        tick();
        pop_exp();
        checks++; if (bus.gnt_vld !== 1'b1) begin errors++;
            $display("FAIL fg_vld: got %b want 1", bus.gnt_vld); end
        checks++; if (bus.gnt_idx !== exp_idx) begin errors++;
            $display("FAIL fg_idx: got %0d want %0d", bus.gnt_idx, exp_idx); end
        checks++; if (bus.gnt_oh !== (8'h01 << exp_idx)) begin errors++;
            $display("FAIL fg_oh: got %h want %h", bus.gnt_oh,
                     8'h01 << exp_idx); end
        last_idx = exp_idx;
        // Owner drops its bit and others churn; grant must not move.
        bus.req = 8'h00;
        tick();
        bus.req = 8'h01;
        tick();
        checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== last_idx) begin
            errors++;
            $display("FAIL fg_hold: got vld=%b idx=%0d want vld=1 idx=%0d",
                     bus.gnt_vld, bus.gnt_idx, last_idx); end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++; if (bus.gnt_vld !== 1'b0 || bus.gnt_oh !== 8'h00) begin
            errors++;
            $display("FAIL fg_rel: got vld=%b oh=%h want 0/00",
                     bus.gnt_vld, bus.gnt_oh); end
        checks++; if (bus.tout !== 1'b0) begin errors++;
            $display("FAIL fg_rel_tout: got %b want 0", bus.tout); end
        tick();
        checks++; if (bus.gnt_vld !== 1'b0 || bus.gnt_idx !== last_idx) begin
            errors++;
            $display("FAIL fg_idle_idx: got vld=%b idx=%0d want 0/%0d",
                     bus.gnt_vld, bus.gnt_idx, last_idx); end
    endtask

    task automatic test_back_to_back();
        bus.req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            push_exp(bus.req);
            tick();
            pop_exp();
            checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_idx) begin
                errors++;
                $display("FAIL b2b_grant%0d: got vld=%b idx=%0d want 1/%0d",
                         n, bus.gnt_vld, bus.gnt_idx, exp_idx); end
            checks++; if (bus.gnt_oh !== (8'h01 << exp_idx)) begin errors++;
                $display("FAIL b2b_oh%0d: got %h want %h", n, bus.gnt_oh,
                         8'h01 << exp_idx); end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            checks++; if (bus.gnt_vld !== 1'b0) begin errors++;
                $display("FAIL b2b_turn%0d: got vld=%b want 0", n,
                         bus.gnt_vld); end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        bus.req = 8'h40;
        push_exp(bus.req);
        tick();
        pop_exp();
        checks++; if (bus.gnt_idx !== exp_idx) begin errors++;
            $display("FAIL wrap_pre: got %0d want %0d", bus.gnt_idx, exp_idx); end
        bus.req  = 8'h81;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        for (int n = 0; n < 2; n++) begin
            push_exp(bus.req);
            tick();
            pop_exp();
            checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_idx) begin
                errors++;
                $display("FAIL wrap%0d: got vld=%b idx=%0d want 1/%0d", n,
                         bus.gnt_vld, bus.gnt_idx, exp_idx); end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_timeout(input logic done_last);
        bus.req = 8'h10;
        push_exp(bus.req);
        tick();
        pop_exp();
        bus.req = 8'h00;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_idx) begin
                errors++;
                $display("FAIL to_hold c%0d: got vld=%b idx=%0d want 1/%0d", c,
                         bus.gnt_vld, bus.gnt_idx, exp_idx); end
            checks++; if (bus.tout !== 1'b0) begin errors++;
                $display("FAIL to_early c%0d: got %b want 0", c, bus.tout); end
            if (c == 4) bus.done = done_last;
            tick();
        end
        bus.done = 1'b0;
        checks++; if (bus.gnt_vld !== 1'b0) begin errors++;
            $display("FAIL to_drop: got vld=%b want 0", bus.gnt_vld); end
        checks++; if (bus.tout !== !done_last) begin errors++;
            $display("FAIL to_pulse d=%b: got %b want %b", done_last,
                     bus.tout, !done_last); end
        tick();
        checks++; if (bus.tout !== 1'b0) begin errors++;
            $display("FAIL to_width: got %b want 0", bus.tout); end
    endtask

    task automatic test_reset_mid();
        bus.req = 8'h02;
        push_exp(bus.req);
        tick();
        pop_exp();
        checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_idx) begin
            errors++;
            $display("FAIL rm_grant: got vld=%b idx=%0d want 1/%0d",
                     bus.gnt_vld, bus.gnt_idx, exp_idx); end
        bus.req = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.gnt_vld !== 1'b0 || bus.gnt_oh !== 8'h00) begin
            errors++;
            $display("FAIL rm_async: got vld=%b oh=%h want 0/00",
                     bus.gnt_vld, bus.gnt_oh); end
        checks++; if (bus.gnt_idx !== 3'd0 || bus.tout !== 1'b0) begin
            errors++;
            $display("FAIL rm_vals: got idx=%0d tout=%b want 0/0",
                     bus.gnt_idx, bus.tout); end
        model_ptr = 3'd0;
        @(negedge clk);
        bus.req = 8'h08;
        rst     = 1'b0;
        push_exp(bus.req);
        tick();
        pop_exp();
        checks++; if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_idx) begin
            errors++;
            $display("FAIL rm_first: got vld=%b idx=%0d want 1/%0d",
                     bus.gnt_vld, bus.gnt_idx, exp_idx); end
        checks++; if (bus.tout !== 1'b0) begin errors++;
            $display("FAIL rm_tout: got %b want 0", bus.tout); end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_grant();
        test_back_to_back();
        test_wrap();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++;
            $display("FAIL sb_left: got %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
